// File: rtl/assertion_timer_bank_pkg.sv
// Shared types and default sizing for the assertion timer bank.
// Channels stretch (echo) or delay (trip) single-cycle trigger pulses.
package assertion_timer_bank_pkg;

  typedef enum logic [1:0] {
    AMODE_OFF      = 2'b00,
    AMODE_ECHO_IMM = 2'b01,
    AMODE_ECHO_DLY = 2'b10,
    AMODE_TRIP     = 2'b11
  } amode_t;

  localparam int DEF_CH      = 4;
  localparam int DEF_LAT_W   = 3;
  localparam int DEF_MAX_LAT = 7;

  function automatic logic isEcho(input amode_t m);
    return (m == AMODE_ECHO_IMM) || (m == AMODE_ECHO_DLY);
  endfunction

endpackage

// File: rtl/assertion_timer_bank_channel.sv
// One channel of the bank: a hold-for-N down-counter (echo modes) and a
// delay-by-N shift register (trip mode), with flush taking priority over both.
module assertion_timer_channel
  import assertion_timer_bank_pkg::*;
#(
  parameter int LAT_W   = DEF_LAT_W,
  parameter int MAX_LAT = DEF_MAX_LAT
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             trigger,
  input  logic             flush,
  input  amode_t           mode,
  input  logic [LAT_W-1:0] latency,
  output logic             assertion,
  output logic             busy
);

  localparam logic [LAT_W-1:0] MAX_L = LAT_W'(MAX_LAT);

  logic [LAT_W-1:0]   r_timer;
  logic [MAX_LAT-1:0] r_tripsr;
  logic [LAT_W-1:0]   w_timerNext;
  logic [MAX_LAT-1:0] w_tripNext;
  logic [LAT_W-1:0]   w_effLat;
  logic               w_timerOn;
  logic               w_trig;
  logic               w_tripTap;

  assign w_effLat  = (latency > MAX_L) ? MAX_L : latency;
  assign w_timerOn = (r_timer != '0);
  assign w_trig    = trigger & ~flush;
  assign busy      = w_timerOn | (|r_tripsr);

  // Tap selection by explicit compare keeps the index in range for any L.
  always_comb begin
    w_tripTap = w_trig;
    for (int k = 1; k <= MAX_LAT; k++) begin
      if (w_effLat == LAT_W'(k)) begin
        w_tripTap = r_tripsr[k-1];
      end
    end
  end

  always_comb begin
    w_timerNext = '0;
    w_tripNext  = '0;
    assertion   = 1'b0;
    if (!flush) begin
      case (mode)
        AMODE_ECHO_IMM, AMODE_ECHO_DLY: begin
          if (trigger) begin
            w_timerNext = w_effLat;
          end else if (w_timerOn) begin
            w_timerNext = r_timer - 1'b1;
          end
          assertion = w_timerOn | (trigger & (mode == AMODE_ECHO_IMM));
        end
        AMODE_TRIP: begin
          w_tripNext[0] = trigger;
          for (int k = 1; k < MAX_LAT; k++) begin
            w_tripNext[k] = r_tripsr[k-1];
          end
          assertion = w_tripTap;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_timer  <= '0;
      r_tripsr <= '0;
    end else begin
      r_timer  <= w_timerNext;
      r_tripsr <= w_tripNext;
    end
  end

endmodule

// File: rtl/assertion_timer_bank.sv
// Bank of independent assertion timer channels sharing one clock and reset.
// Mode and latency arrive as packed per-channel buses and are sliced here.
module assertion_timer_bank
  import assertion_timer_bank_pkg::*;
#(
  parameter int CH      = DEF_CH,
  parameter int LAT_W   = DEF_LAT_W,
  parameter int MAX_LAT = DEF_MAX_LAT
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [CH-1:0]       trigger,
  input  logic [CH-1:0]       flush,
  input  logic [2*CH-1:0]     mode,
  input  logic [LAT_W*CH-1:0] latency,
  output logic [CH-1:0]       assertion,
  output logic [CH-1:0]       busy
);

  for (genvar i = 0; i < CH; i++) begin : g_ch
    amode_t w_mode;
    assign w_mode = amode_t'(mode[2*i +: 2]);

    assertion_timer_channel #(
      .LAT_W   (LAT_W),
      .MAX_LAT (MAX_LAT)
    ) u_channel (
      .clk       (clk),
      .rstn      (rstn),
      .trigger   (trigger[i]),
      .flush     (flush[i]),
      .mode      (w_mode),
      .latency   (latency[LAT_W*i +: LAT_W]),
      .assertion (assertion[i]),
      .busy      (busy[i])
    );
  end

endmodule
